decade_tracker: RTL and testbench
=================================

# decade_tracker

Downstream stage of the decade counter: samples the counter's 4-bit BCD output `Q` every clock, detects 9→0 rollovers, and extends the count with `NDIGITS` further BCD digits. It also drives a registered 7-segment code for the live digit, flags illegal codes, and offers a valid/ready snapshot of the full multi-digit count to a consumer. It sits between the counter and any display or logging stage, connected at the top level alongside the counter and the testbench.

## Interface
- `NDIGITS`, default 3: number of upper BCD digits held by the tracker (supported range 1..8).
- `CLK`  in  1: single clock, all state on posedge.
- `MR_n`  in  1: asynchronous, active-low reset.
- `Q`  in  4: counter output, sampled every posedge.
- `Load`  in  1: the counter's parallel-load strobe, wired to the same net that drives the counter.
- `Clear`  in  1: synchronous clear of `Upper`, `Overflow` and `Error`.
- `Snap`  in  1: snapshot request.
- `SnapReady`  in  1: consumer accepts the snapshot.
- `SnapValid`  out  1: snapshot held and valid.
- `SnapData`  out  4*(NDIGITS+1): snapshot, arranged as {Upper, Qd}.
- `Upper`  out  4*NDIGITS: live upper digits. Digit 0 (bits [3:0]) is the tens digit.
- `Carry`  out  1: one-cycle rollover pulse.
- `Overflow`  out  1: sticky; set when the upper digits wrap.
- `Error`  out  1: sticky; set when an illegal code is seen.
- `Seg`  out  7: 7-segment code of the last sample, order gfedcba, active-high.

## Operation
- Internal registers: `Qd` holds the previous `Q`; `Ld` holds the previous `Load`. Both update every posedge.
- Rollover event, evaluated at each posedge: `Qd==9 && Q==0 && !Ld && !Clear`.
  - `Ld` suppresses the event. A counter load takes effect at the same edge where `Load` is sampled, so the following edge's 9→0 step is a load, not a count.
- On a rollover event:
  - `Carry` is 1 for exactly one cycle.
  - `Upper` increments as a BCD ripple. Each digit at 9 goes to 0 and carries into the next digit.
  - If every digit is 9, `Upper` becomes all 0 and `Overflow` is set.
- Illegal code: if `Q>9` is sampled, `Error` is set, and it stays set until `Clear` or reset.
  - A transition into or out of an illegal code is never a rollover.
- `Clear` has priority over a simultaneous rollover:
  - `Upper`, `Overflow` and `Error` go to 0.
  - `Carry` stays 0.
  - If `Q>9` in the same cycle as `Clear`, `Error` is still cleared. It sets again on the next cycle's sample if `Q` is still illegal.
- `Seg` is the registered encode of `Q`:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Codes 10..15 display "E" = 1111001.
- Snapshot handshake, states EMPTY and FULL:
  - EMPTY, `Snap`=1: capture the pre-edge values {Upper, Qd} into `SnapData` and go to FULL.
  - FULL, `SnapReady`=1 and `Snap`=0: go to EMPTY.
  - FULL, `SnapReady`=1 and `Snap`=1: recapture and stay FULL. `SnapValid` stays high.
  - FULL, `SnapReady`=0: `Snap` is ignored, `SnapData` is held stable, stay FULL.
  - `Clear` does not affect the snapshot path.

## Timing
- Reset (`MR_n`=0, asynchronous):
  - Immediately: `Qd`=0, `Ld`=0, `Upper`=0, `Carry`=0, `Overflow`=0, `Error`=0, `Seg`=0000000 (blank), `SnapValid`=0, `SnapData`=0, snapshot state EMPTY.
  - Reset mid-snapshot or mid-ripple drops all state with no partial update.
  - Release is synchronous to the next posedge.
- Latency, with the counter stepping 9→0 at edge n:
  - Detection is at edge n+1.
  - `Carry` is high from edge n+1 to edge n+2.
  - `Upper` shows the new value after edge n+1.
- `Seg` and `Error` reflect `Q` one cycle after it is sampled.
- `SnapValid` rises one cycle after the accepted `Snap` edge.
  - It falls one cycle after the handshake edge (`SnapValid && SnapReady` with no new `Snap`).
  - Minimum snapshot turnaround is 2 cycles.
- Back-to-back rollovers are impossible at `Q` rate (at most one every 10 cycles). Each rollover still completes in one cycle, with no multi-cycle ripple.

## Test plan
- Reset: assert `MR_n`=0 mid-count, between clock edges, with `SnapValid`=1 → all outputs are 0 and `Seg`=0000000 before the next edge.
- Counting: drive `Q` = 0..9,0,1 (`Load`=0) → one `Carry` pulse, high for the cycle after `Q`=0 is sampled; `Upper`=0x001; `Seg`=0111111 one cycle after `Q`=0.
- Load suppression: drive `Q`=9 with `Load`=1 sampled, then `Q`=0 → no `Carry`; `Upper` unchanged. Repeat with `Load`=0 → `Carry` fires.
- Overflow: drive 1000 rollovers with NDIGITS=3 → `Upper` steps 0x999→0x000; `Carry` pulses on that event; `Overflow`=1 and stays set; `Clear` → `Overflow`=0, `Upper`=0x000.
- Error: drive `Q`=4'hC → `Seg`=1111001 and `Error`=1 next cycle; then `Q`=0 following `Qd`=9-illegal → no `Carry`; `Error` stays 1 until `Clear`. Also assert `Clear` together with a valid rollover → no `Carry`, `Upper`=0.
- Snapshot backpressure: with `Upper`=0x012 and `Qd`=7, pulse `Snap` with `SnapReady`=0 for 5 cycles → `SnapValid`=1 and `SnapData`=0x0127 held stable; a second `Snap` is ignored. Raise `SnapReady` → `SnapValid`=0 after one edge. Then hold `Snap` and `SnapReady` high → `SnapValid` continuous, `SnapData` updates every cycle.

Source files
------------

// File: rtl/decade_tracker.sv
// decade_tracker
// Watches a decade counter's BCD output and extends the count with NDIGITS
// further BCD digits. It also produces a registered 7-segment code for the
// live digit, sticky overflow/illegal-code flags, and a valid/ready snapshot
// of the whole count.
//
// Ports:
//   CLK        clock, all state on posedge
//   MR_n       asynchronous active-low reset
//   Q          counter BCD output, sampled every edge
//   Load       counter parallel-load strobe (same net as the counter's)
//   Clear      synchronous clear of Upper / Overflow / Error
//   Snap       snapshot request
//   SnapReady  consumer accepts snapshot
//   SnapValid  snapshot held
//   SnapData   {Upper, Qd} captured at the request edge
//   Upper      upper BCD digits, digit 0 = tens
//   Carry      one-cycle rollover pulse
//   Overflow   sticky, upper digits wrapped
//   Error      sticky, illegal code (Q>9) sampled
//   Seg        gfedcba, active-high encode of the last sample
module decade_tracker #(
    parameter int NDIGITS = 3
) (
    input  logic                       CLK,
    input  logic                       MR_n,
    input  logic [3:0]                 Q,
    input  logic                       Load,
    input  logic                       Clear,
    input  logic                       Snap,
    input  logic                       SnapReady,
    output logic                       SnapValid,
    output logic [4*(NDIGITS+1)-1:0]   SnapData,
    output logic [4*NDIGITS-1:0]       Upper,
    output logic                       Carry,
    output logic                       Overflow,
    output logic                       Error,
    output logic [6:0]                 Seg
);

    typedef enum logic {S_EMPTY, S_FULL} snap_state_t;

    logic [3:0]              r_qd;
    logic                    r_ld;
    logic [4*NDIGITS-1:0]    r_upper;
    logic                    r_carry;
    logic                    r_ovf;
    logic                    r_err;
    logic [6:0]              r_seg;
    logic [4*(NDIGITS+1)-1:0] r_snap_data;
    snap_state_t             r_state;
    snap_state_t             w_next_state;
    logic                    w_capture;
    logic                    w_roll;
    logic [4*NDIGITS-1:0]    w_upper_inc;
    logic [NDIGITS:0]        w_cin;
    logic [6:0]              w_seg;

    // A 9->0 step right after a sampled Load is the load itself, not a count.
    // An illegal previous code can never equal 9, so illegal transitions
    // are excluded without extra logic.
    assign w_roll = (r_qd == 4'd9) && (Q == 4'd0) && !r_ld && !Clear;

    // Single-cycle BCD ripple: each digit passes the carry on only when it
    // is 9. w_cin[NDIGITS] high means every digit was 9 (wrap).
    assign w_cin[0] = 1'b1;
    for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
        logic [3:0] w_dig;
        logic       w_is9;
        assign w_dig = r_upper[4*g +: 4];
        assign w_is9 = (w_dig == 4'd9);
        assign w_upper_inc[4*g +: 4] = !w_cin[g] ? w_dig :
                                       (w_is9 ? 4'd0 : w_dig + 4'd1);
        assign w_cin[g+1] = w_cin[g] & w_is9;
    end

    always_comb begin
        w_seg = 7'b1111001;  // "E" for 10..15
        case (Q)
            4'd0: w_seg = 7'b0111111;
            4'd1: w_seg = 7'b0000110;
            4'd2: w_seg = 7'b1011011;
            4'd3: w_seg = 7'b1001111;
            4'd4: w_seg = 7'b1100110;
            4'd5: w_seg = 7'b1101101;
            4'd6: w_seg = 7'b1111101;
            4'd7: w_seg = 7'b0000111;
            4'd8: w_seg = 7'b1111111;
            4'd9: w_seg = 7'b1101111;
            default: w_seg = 7'b1111001;
        endcase
    end

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            r_qd    <= '0;
            r_ld    <= 1'b0;
            r_upper <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_seg   <= '0;
        end else begin
            r_qd    <= Q;
            r_ld    <= Load;
            r_carry <= w_roll;
            r_seg   <= w_seg;
            if (Clear) begin
                // Clear wins over rollover and over an illegal sample.
                r_upper <= '0;
                r_ovf   <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                if (w_roll) begin
                    r_upper <= w_upper_inc;
                    if (w_cin[NDIGITS]) r_ovf <= 1'b1;
                end
                if (Q > 4'd9) r_err <= 1'b1;
            end
        end
    end

    // Snapshot handshake
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            r_state     <= S_EMPTY;
            r_snap_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) r_snap_data <= {r_upper, r_qd};
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (Snap) begin
                    w_capture    = 1'b1;
                    w_next_state = S_FULL;
                end
            end
            S_FULL: begin
                // Data held stable until the consumer takes it.
                if (SnapReady) begin
                    if (Snap) w_capture    = 1'b1;
                    else      w_next_state = S_EMPTY;
                end
            end
            default: w_next_state = S_EMPTY;
        endcase
    end

    assign SnapValid = (r_state == S_FULL);
    assign SnapData  = r_snap_data;
    assign Upper     = r_upper;
    assign Carry     = r_carry;
    assign Overflow  = r_ovf;
    assign Error     = r_err;
    assign Seg       = r_seg;

endmodule

// File: tb/tb_decade_tracker.sv
// Self-checking bench for decade_tracker: directed scenarios with literal
// expectations plus randomized counter-like stimulus, all outputs compared
// every cycle against an arithmetic model of the count.
module tb_decade_tracker;

    localparam int ND  = 3;
    localparam int LIM = 1000;  // 10**ND

    logic               CLK = 1'b0;
    logic               MR_n = 1'b1;
    logic [3:0]         Q = '0;
    logic               Load = 1'b0;
    logic               Clear = 1'b0;
    logic               Snap = 1'b0;
    logic               SnapReady = 1'b0;
    logic               SnapValid;
    logic [4*(ND+1)-1:0] SnapData;
    logic [4*ND-1:0]    Upper;
    logic               Carry;
    logic               Overflow;
    logic               Error;
    logic [6:0]         Seg;

    decade_tracker #(.NDIGITS(ND)) dut (
        .CLK(CLK), .MR_n(MR_n), .Q(Q), .Load(Load), .Clear(Clear),
        .Snap(Snap), .SnapReady(SnapReady), .SnapValid(SnapValid),
        .SnapData(SnapData), .Upper(Upper), .Carry(Carry),
        .Overflow(Overflow), .Error(Error), .Seg(Seg)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] SEGTAB [16];
    initial begin
        SEGTAB[0] = 7'b0111111; SEGTAB[1] = 7'b0000110; SEGTAB[2] = 7'b1011011;
        SEGTAB[3] = 7'b1001111; SEGTAB[4] = 7'b1100110; SEGTAB[5] = 7'b1101101;
        SEGTAB[6] = 7'b1111101; SEGTAB[7] = 7'b0000111; SEGTAB[8] = 7'b1111111;
        SEGTAB[9] = 7'b1101111;
        for (int i = 10; i < 16; i++) SEGTAB[i] = 7'b1111001;
    end

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r;
        int p;
        r = '0;
        p = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(p % 10);
            p = p / 10;
        end
        return r;
    endfunction

    // Model keeps the upper count as a plain integer modulo 10**ND.
    int                  m_cnt = 0;
    logic [3:0]          m_pq = '0;
    logic                m_pld = 1'b0;
    logic                m_carry = 1'b0;
    logic                m_ovf = 1'b0;
    logic                m_err = 1'b0;
    logic [6:0]          m_seg = '0;
    logic                m_full = 1'b0;
    logic [4*(ND+1)-1:0] m_sd = '0;
    logic                m_roll;

    assign m_roll = (m_pq == 4'd9) && (Q == 4'd0) && !m_pld && !Clear;

    always @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            m_cnt <= 0; m_pq <= '0; m_pld <= 1'b0; m_carry <= 1'b0;
            m_ovf <= 1'b0; m_err <= 1'b0; m_seg <= '0; m_full <= 1'b0; m_sd <= '0;
        end else begin
            m_pq    <= Q;
            m_pld   <= Load;
            m_carry <= m_roll;
            m_seg   <= SEGTAB[Q];
            if (Clear) begin
                m_cnt <= 0; m_ovf <= 1'b0; m_err <= 1'b0;
            end else begin
                if (m_roll) begin
                    m_cnt <= (m_cnt + 1) % LIM;
                    if (m_cnt == LIM - 1) m_ovf <= 1'b1;
                end
                if (Q > 4'd9) m_err <= 1'b1;
            end
            if (!m_full) begin
                if (Snap) begin m_full <= 1'b1; m_sd <= {to_bcd(m_cnt), m_pq}; end
            end else if (SnapReady) begin
                if (Snap) m_sd <= {to_bcd(m_cnt), m_pq};
                else      m_full <= 1'b0;
            end
        end
    end

    // Compare process
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("upper",     64'(Upper),     64'(to_bcd(m_cnt)));
            chk("carry",     64'(Carry),     64'(m_carry));
            chk("overflow",  64'(Overflow),  64'(m_ovf));
            chk("error",     64'(Error),     64'(m_err));
            chk("seg",       64'(Seg),       64'(m_seg));
            chk("snapvalid", 64'(SnapValid), 64'(m_full));
            chk("snapdata",  64'(SnapData),  64'(m_sd));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [3:0] q, input logic ld = 1'b0, input logic clr = 1'b0,
                         input logic sn = 1'b0, input logic rd = 1'b0);
        Q = q; Load = ld; Clear = clr; Snap = sn; SnapReady = rd;
        @(negedge CLK);
    endtask

    task automatic rollovers(input int n);
        for (int i = 0; i < n; i++) begin
            for (int d = 1; d <= 9; d++) drive(4'(d));
            drive(4'd0);
        end
    endtask

    initial begin
        int tq;
        logic [3:0] q;
        logic ld, clr, sn, rd;

        #1 MR_n = 1'b0;
        #1;
        chk("reset_upper", 64'(Upper), 64'h0);
        chk("reset_seg",   64'(Seg),   64'h0);
        cmp_en = 1'b1;
        repeat (2) @(negedge CLK);
        MR_n = 1'b1;

        // Counting 0..9,0,1
        for (int d = 0; d <= 9; d++) drive(4'(d));
        chk("cnt_nocarry", 64'(Carry), 64'h0);
        drive(4'd0);
        chk("cnt_carry", 64'(Carry), 64'h1);
        chk("cnt_upper", 64'(Upper), 64'h001);
        chk("cnt_seg0",  64'(Seg),   64'b0111111);
        drive(4'd1);
        chk("cnt_carry_off", 64'(Carry), 64'h0);

        // Load suppression
        drive(4'd9, 1'b1);
        drive(4'd0);
        chk("load_nocarry", 64'(Carry), 64'h0);
        chk("load_upper",   64'(Upper), 64'h001);
        drive(4'd9);
        drive(4'd0);
        chk("load_carry", 64'(Carry), 64'h1);
        chk("load_upper2", 64'(Upper), 64'h002);

        // Illegal code and clear-vs-rollover
        drive(4'hC);
        chk("err_seg", 64'(Seg),   64'b1111001);
        chk("err_set", 64'(Error), 64'h1);
        drive(4'd9);
        drive(4'hE);
        drive(4'd0);
        chk("err_nocarry", 64'(Carry), 64'h0);
        chk("err_sticky",  64'(Error), 64'h1);
        drive(4'd9);
        drive(4'd0, 1'b0, 1'b1);
        chk("clr_nocarry", 64'(Carry), 64'h0);
        chk("clr_upper",   64'(Upper), 64'h0);
        chk("clr_err",     64'(Error), 64'h0);
        drive(4'hB, 1'b0, 1'b1);
        chk("clr_err_illegal", 64'(Error), 64'h0);
        drive(4'hB);
        chk("err_reset_again", 64'(Error), 64'h1);

        // Overflow after 1000 rollovers
        drive(4'd0, 1'b0, 1'b1);
        rollovers(LIM - 1);
        chk("ovf_999", 64'(Upper), 64'h999);
        chk("ovf_pre", 64'(Overflow), 64'h0);
        rollovers(1);
        chk("ovf_wrap",  64'(Upper),    64'h000);
        chk("ovf_carry", 64'(Carry),    64'h1);
        chk("ovf_set",   64'(Overflow), 64'h1);
        drive(4'd1);
        chk("ovf_sticky", 64'(Overflow), 64'h1);
        drive(4'd2, 1'b0, 1'b1);
        chk("ovf_clear", 64'(Overflow), 64'h0);

        // Snapshot backpressure
        drive(4'd0, 1'b0, 1'b1);
        rollovers(12);
        drive(4'd7);
        drive(4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("snap_valid", 64'(SnapValid), 64'h1);
        chk("snap_data",  64'(SnapData),  64'h0127);
        for (int i = 0; i < 4; i++) drive(4'd8, 1'b0, 1'b0, 1'(i % 2), 1'b0);
        chk("snap_hold", 64'(SnapData), 64'h0127);
        drive(4'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("snap_drop", 64'(SnapValid), 64'h0);
        drive(4'd8, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("snap_cap2", 64'(SnapData), 64'h0127);
        drive(4'd9, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("snap_stream_v", 64'(SnapValid), 64'h1);
        chk("snap_stream_d", 64'(SnapData),  64'h0128);
        drive(4'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("snap_stream_d2", 64'(SnapData), 64'h0129);

        // Randomized counter-like traffic
        tq = 0;
        for (int n = 0; n < 4000; n++) begin
            ld  = (tq == 9) ? ($urandom_range(3) == 0) : ($urandom_range(99) < 5);
            clr = ($urandom_range(99) < 2);
            sn  = 1'($urandom_range(1));
            rd  = 1'($urandom_range(1));
            q   = 4'(tq);
            if ($urandom_range(99) < 3) q = 4'($urandom_range(15, 10));
            drive(q, ld, clr, sn, rd);
            tq = ld ? int'($urandom_range(9)) : ((tq == 9) ? 0 : tq + 1);
        end

        // Asynchronous reset with a snapshot held, between edges
        drive(4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(4'd4);
        #2 MR_n = 1'b0;
        #1;
        chk("areset_valid", 64'(SnapValid), 64'h0);
        chk("areset_data",  64'(SnapData),  64'h0);
        chk("areset_seg",   64'(Seg),       64'h0);
        chk("areset_upper", 64'(Upper),     64'h0);
        @(negedge CLK);
        MR_n = 1'b1;
        for (int d = 0; d < 5; d++) drive(4'(d));

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
